instr_fetch_ctrl: RTL

Sequences instruction fetch for the fetch/decode stage. Owns the fetch address (segment in pstate0, offset in pstate1) and runs the req/ack handshake with the I-memory interface. Holds one fetched instruction in an output buffer until decode accepts it. Also handles branch/trap redirects, flushes, and fetch faults (bus error, timeout, misaligned target).

---
 rtl/instr_fetch_ctrl_if.sv | 22 ++
 rtl/instr_fetch_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl_if.sv
// Instruction-memory fetch bus between the fetch controller (master)
// and the I-memory (slave). The request holds its address until acked.
interface instr_fetch_ctrl_if #(
    parameter int WORD_LENGTH = 32
);
    logic                   imemReq;
    logic [WORD_LENGTH-1:0] imemSeg;
    logic [WORD_LENGTH-1:0] imemOfs;
    logic                   imemAck;
    logic [WORD_LENGTH-1:0] imemData;
    logic                   imemErr;

    modport master (
        output imemReq, imemSeg, imemOfs,
        input  imemAck, imemData, imemErr
    );

    modport slave (
        input  imemReq, imemSeg, imemOfs,
        output imemAck, imemData, imemErr
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC (segment/offset), runs the
// I-memory req/ack handshake, buffers one instruction for decode and turns
// redirects, bus errors, timeouts and misaligned targets into fetch traps.
//
// state | meaning
// IDLE  | one settling cycle after reset release
// FETCH | issuing requests at the PC whenever the output buffer is free
// DRAIN | waiting out a request abandoned by redirect; its data is dropped
// TRAP  | fetch fault pending; only a redirect leaves
module instr_fetch_ctrl #(
    parameter int                     WORD_LENGTH = 32,
    parameter logic [WORD_LENGTH-1:0] RESET_SEG   = '0,
    parameter logic [WORD_LENGTH-1:0] RESET_OFS   = '0,
    parameter int                     WAIT_LIMIT  = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [WORD_LENGTH-1:0] redirectSeg,
    input  logic [WORD_LENGTH-1:0] redirectOfs,
    instr_fetch_ctrl_if.master     imem,
    output logic                   instrValid,
    output logic [WORD_LENGTH-1:0] instr,
    output logic [WORD_LENGTH-1:0] outPstate0,
    output logic [WORD_LENGTH-1:0] outPstate1,
    output logic                   fetchTrap,
    output logic [1:0]             trapCode
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    localparam logic [1:0] TRAP_NONE     = 2'b00;
    localparam logic [1:0] TRAP_BUS_ERR  = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT  = 2'b10;
    localparam logic [1:0] TRAP_MISALIGN = 2'b11;

    // The trap is taken on the last unacked cycle, so the request is seen
    // for exactly WAIT_LIMIT cycles before it drops.
    localparam logic [7:0]             WAIT_LAST = 8'(WAIT_LIMIT - 1);
    localparam logic [WORD_LENGTH-1:0] OFS_STEP  = WORD_LENGTH'(4);

    state_t                 state_q, state_d;
    logic [WORD_LENGTH-1:0] pc_seg_q, pc_seg_d;
    logic [WORD_LENGTH-1:0] pc_ofs_q, pc_ofs_d;
    logic [WORD_LENGTH-1:0] tgt_seg_q, tgt_seg_d;
    logic [WORD_LENGTH-1:0] tgt_ofs_q, tgt_ofs_d;
    logic [WORD_LENGTH-1:0] instr_q, instr_d;
    logic [WORD_LENGTH-1:0] out_seg_q, out_seg_d;
    logic [WORD_LENGTH-1:0] out_ofs_q, out_ofs_d;
    logic                   valid_q, valid_d;
    logic [1:0]             trap_code_q, trap_code_d;
    logic [7:0]             wait_cnt_q, wait_cnt_d;

    logic                   req;
    logic                   buf_free;
    logic                   misaligned;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pc_seg_q    <= RESET_SEG;
            pc_ofs_q    <= RESET_OFS;
            tgt_seg_q   <= '0;
            tgt_ofs_q   <= '0;
            instr_q     <= '0;
            out_seg_q   <= '0;
            out_ofs_q   <= '0;
            valid_q     <= 1'b0;
            trap_code_q <= TRAP_NONE;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_seg_q    <= pc_seg_d;
            pc_ofs_q    <= pc_ofs_d;
            tgt_seg_q   <= tgt_seg_d;
            tgt_ofs_q   <= tgt_ofs_d;
            instr_q     <= instr_d;
            out_seg_q   <= out_seg_d;
            out_ofs_q   <= out_ofs_d;
            valid_q     <= valid_d;
            trap_code_q <= trap_code_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    // Next-state, request and buffer logic; redirect overrides everything.
    always_comb begin
        state_d     = state_q;
        pc_seg_d    = pc_seg_q;
        pc_ofs_d    = pc_ofs_q;
        tgt_seg_d   = tgt_seg_q;
        tgt_ofs_d   = tgt_ofs_q;
        instr_d     = instr_q;
        out_seg_d   = out_seg_q;
        out_ofs_d   = out_ofs_q;
        valid_d     = valid_q;
        trap_code_d = trap_code_q;
        wait_cnt_d  = wait_cnt_q;
        req         = 1'b0;
        // Free when empty or being consumed by decode this cycle.
        buf_free    = !valid_q || !stall;
        misaligned  = (redirectOfs[1:0] != 2'b00);

        unique case (state_q)
            S_IDLE: begin
                state_d    = S_FETCH;
                wait_cnt_d = '0;
            end
            S_FETCH: begin
                req = buf_free;
                if (req) begin
                    if (imem.imemAck) begin
                        wait_cnt_d = '0;
                        if (imem.imemErr) begin
                            state_d     = S_TRAP;
                            trap_code_d = TRAP_BUS_ERR;
                            valid_d     = 1'b0;
                        end else begin
                            instr_d   = imem.imemData;
                            out_seg_d = pc_seg_q;
                            out_ofs_d = pc_ofs_q;
                            valid_d   = 1'b1;
                            pc_ofs_d  = pc_ofs_q + OFS_STEP;
                        end
                    end else begin
                        // Any buffered instruction is being consumed now.
                        valid_d = 1'b0;
                        if (wait_cnt_q == WAIT_LAST) begin
                            state_d     = S_TRAP;
                            trap_code_d = TRAP_TIMEOUT;
                            wait_cnt_d  = '0;
                        end else begin
                            wait_cnt_d = wait_cnt_q + 8'd1;
                        end
                    end
                end
            end
            S_DRAIN: begin
                req = 1'b1;
                if (imem.imemAck) begin
                    state_d    = S_FETCH;
                    pc_seg_d   = tgt_seg_q;
                    pc_ofs_d   = tgt_ofs_q;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d     = S_TRAP;
                    trap_code_d = TRAP_TIMEOUT;
                    wait_cnt_d  = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_TRAP: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (redirect) begin
            valid_d    = 1'b0;
            instr_d    = instr_q;
            out_seg_d  = out_seg_q;
            out_ofs_d  = out_ofs_q;
            wait_cnt_d = '0;
            if (misaligned) begin
                state_d     = S_TRAP;
                trap_code_d = TRAP_MISALIGN;
                pc_seg_d    = pc_seg_q;
                pc_ofs_d    = pc_ofs_q;
            end else if (req && !imem.imemAck) begin
                // Old request must complete on the bus before the new one.
                state_d     = S_DRAIN;
                trap_code_d = TRAP_NONE;
                pc_seg_d    = pc_seg_q;
                pc_ofs_d    = pc_ofs_q;
                tgt_seg_d   = redirectSeg;
                tgt_ofs_d   = redirectOfs;
            end else begin
                state_d     = S_FETCH;
                trap_code_d = TRAP_NONE;
                pc_seg_d    = redirectSeg;
                pc_ofs_d    = redirectOfs;
            end
        end
    end

    assign imem.imemReq = req;
    assign imem.imemSeg = pc_seg_q;
    assign imem.imemOfs = pc_ofs_q;

    assign instrValid = valid_q;
    assign instr      = instr_q;
    assign outPstate0 = out_seg_q;
    assign outPstate1 = out_ofs_q;
    assign fetchTrap  = (state_q == S_TRAP);
    assign trapCode   = trap_code_q;

endmodule
